// File: rtl/spike_shift_pkg.sv
// rtl/spike_shift_pkg.sv - shared types and helpers for the spike shift scheduler
// Contents: scheduler state enum, shift-field width, zero-shift pattern,
//           one-hot-or-zero test for shift fields up to 32 bits.
package spike_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  function automatic int shift_w(input int max_mag);
    return 2 * max_mag + 1;
  endfunction

  // The shift field is [0:SW-1] with the centre at index max_mag. The field
  // is symmetric, so that index is also numeric bit position max_mag.
  function automatic logic [31:0] zero_shift(input int max_mag);
    return 32'd1 << max_mag;
  endfunction

  function automatic logic is_onehot_or_zero(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/spike_shift_scheduler_rr_arbiter.sv
// rtl/spike_shift_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Ports: req   - request bits
//        ptr   - requester searched first
//        en    - when low no grant is produced
//        gnt   - one-hot grant (all zero when nothing wins)
//        gnt_id- binary index of the winner (0 when no grant)
module rr_arbiter
  import spike_shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id
);

  logic           found;
  logic [IDW-1:0] idx;

  // Walk the requesters circularly from ptr; the first pending one wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/spike_shift_scheduler.sv
// rtl/spike_shift_scheduler.sv - round-robin sharing of one registered spike shifter
// Ports: clock/reset          - clock, synchronous active-high reset
//        req_valid/req_ready  - per-requester handshake (ready = grant)
//        req_data/req_shift   - flattened per-requester volley and one-hot shift
//        sh_ip/sh_shift/sh_op - external shifter drive and its 1-cycle result
//        rsp_*                - shifted volley, owner ID and illegal-shift flag
//        busy                 - a transaction is in flight
module spike_shift_scheduler
  import spike_shift_pkg::*;
#(
  parameter int  LEN           = 8,
  parameter int  MAX_SHIFT_MAG = 2,
  parameter int  NUM_REQ       = 4,
  parameter int  IDW           = $clog2(NUM_REQ),
  localparam int SW            = shift_w(MAX_SHIFT_MAG)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*LEN-1:0] req_data,
  input  logic [NUM_REQ*SW-1:0]  req_shift,
  output logic [0:LEN-1]         sh_ip,
  output logic [0:SW-1]          sh_shift,
  input  logic [0:LEN-1]         sh_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [0:LEN-1]         rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam logic [0:SW-1] ZS = SW'(zero_shift(MAX_SHIFT_MAG));

  sched_state_t   state_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lat_id_q;
  logic           lat_err_q;
  logic [0:LEN-1] sh_ip_q;
  logic [0:SW-1]  sh_shift_q;
  logic           rsp_valid_q;
  logic [0:LEN-1] rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_err_q;
  logic           busy_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               arb_en;
  logic [0:LEN-1]     sel_data;
  logic [0:SW-1]      sel_shift, san_shift;
  logic [31:0]        shift_ext;
  logic               sel_err;

  // No grant while reset is asserted, so nothing is accepted in that cycle.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .en    (arb_en),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  assign req_ready = gnt;

  // Select the winner's fields and sanitise its shift: an empty or multi-hot
  // field becomes the centre (zero) shift; multi-hot also flags an error.
  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data  = req_data[i*LEN +: LEN];
        sel_shift = req_shift[i*SW +: SW];
      end
    end
    shift_ext = 32'(sel_shift);
    sel_err   = !is_onehot_or_zero(shift_ext);
    san_shift = (sel_err || (sel_shift == '0)) ? ZS : sel_shift;
    rr_ptr_d  = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lat_id_q    <= '0;
      lat_err_q   <= 1'b0;
      sh_ip_q     <= '0;
      sh_shift_q  <= ZS;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            // The volley goes straight into the shifter drive registers, so
            // ISSUE presents it without a separate holding copy.
            sh_ip_q    <= sel_data;
            sh_shift_q <= san_shift;
            lat_id_q   <= gnt_id;
            lat_err_q  <= sel_err;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          sh_ip_q    <= '0;
          sh_shift_q <= ZS;
          state_q    <= WAIT;
        end
        WAIT: begin
          rsp_data_q  <= sh_op;
          rsp_id_q    <= lat_id_q;
          rsp_err_q   <= lat_err_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sh_ip     = sh_ip_q;
  assign sh_shift  = sh_shift_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spike_shift_scheduler.sv
// tb/tb_spike_shift_scheduler.sv - self-checking bench for spike_shift_scheduler
module tb_spike_shift_scheduler;

  localparam int LEN = 8;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int SW  = 5;
  localparam logic [4:0] ZS = 5'b00100;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*LEN-1:0] req_data = '0;
  logic [NR*SW-1:0]  req_shift = '0;
  logic [7:0]        sh_ip;
  logic [4:0]        sh_shift;
  logic [7:0]        sh_op = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [7:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  spike_shift_scheduler #(
    .LEN(LEN), .MAX_SHIFT_MAG(2), .NUM_REQ(NR), .IDW(IDW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift),
    .sh_ip(sh_ip), .sh_shift(sh_shift), .sh_op(sh_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Shift by (index - 2): literal bit p is field index 4-p, so amount = 2-p.
  // Positive amounts move toward the literal MSB; no wrap-around.
  function automatic logic [7:0] model_shift(input logic [7:0] d, input logic [4:0] s);
    int p = -1;
    for (int i = 0; i < 5; i++) if (s[i]) p = i;
    if (p < 0) return 8'h00;
    if (p <= 2) return d << (2 - p);
    return d >> (p - 2);
  endfunction

  function automatic logic [4:0] model_sanitise(input logic [4:0] s);
    if ($countones(s) == 1) return s;
    return ZS;
  endfunction

  function automatic logic [4:0] rnd_shift();
    int r = $urandom_range(0, 9);
    if (r < 5) return 5'b00001 << $urandom_range(0, 4);
    if (r < 7) return 5'b00000;
    return 5'($urandom);
  endfunction

  always @(posedge clock) sh_op <= model_shift(sh_ip, sh_shift);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int id, input logic [7:0] d, input logic [4:0] s);
    req_data[id*LEN +: LEN] = d;
    req_shift[id*SW +: SW]  = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      if (!busy) break;
      tick();
      #1;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [4:0] shift;
    logic [7:0] exp_data;
    logic [4:0] exp_sh;
    logic       exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.id;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    set_slot(v.id, v.data, v.shift);
    rsp_ready = 1'b1;
    #1;
    check("vec_grant", 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    #1;
    check("vec_issue_ip", 32'(sh_ip), 32'(v.data));
    check("vec_issue_shift", 32'(sh_shift), 32'(v.exp_sh));
    check("vec_issue_busy", 32'(busy), 32'd1);
    tick();
    #1;
    check("vec_wait_valid", 32'(rsp_valid), 32'd0);
    check("vec_wait_shift", 32'(sh_shift), 32'(ZS));
    tick();
    #1;
    check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
    check("vec_rsp_data", 32'(rsp_data), 32'(v.exp_data));
    check("vec_rsp_id", 32'(rsp_id), 32'(v.id));
    check("vec_rsp_err", 32'(rsp_err), 32'(v.exp_err));
    tick();
    #1;
    check("vec_done_valid", 32'(rsp_valid), 32'd0);
    check("vec_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   gcount, last_c, gidx, seen;
    int   ptr_m, cd, w, j, e_id;
    logic m_busy, e_err;
    logic [7:0] e_data;
    logic [3:0] exp_rdy;

    vecs[0] = '{0, 8'b0000_0010, 5'b00010, 8'b0000_0100, 5'b00010, 1'b0};
    vecs[1] = '{2, 8'b0110_0011, 5'b10010, 8'b0110_0011, 5'b00100, 1'b1};
    vecs[2] = '{3, 8'b0000_1000, 5'b00000, 8'b0000_1000, 5'b00100, 1'b0};
    vecs[3] = '{3, 8'b0000_1000, 5'b10000, 8'b0000_0010, 5'b10000, 1'b0};
    vecs[4] = '{1, 8'h81,        5'b00001, 8'h04,        5'b00001, 1'b0};
    vecs[5] = '{1, 8'h81,        5'b01000, 8'h40,        5'b01000, 1'b0};
    vecs[6] = '{0, 8'hFF,        5'b00100, 8'hFF,        5'b00100, 1'b0};
    vecs[7] = '{2, 8'h0F,        5'b11111, 8'h0F,        5'b00100, 1'b1};

    // Reset: no grant while reset is high, then all reset values.
    reset = 1'b1;
    req_valid = '1;
    tick();
    tick();
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    req_valid = '0;
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sh_ip", 32'(sh_ip), 32'd0);
    check("reset_sh_shift", 32'(sh_shift), 32'(ZS));

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Round robin with all requesters valid and no back-pressure.
    do_reset();
    for (int i = 0; i < NR; i++) set_slot(i, 8'(8'h10 * (i + 1)), ZS);
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    gcount = 0;
    last_c = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != 0) begin
        check("rr_onehot", 32'($countones(req_ready)), 32'd1);
        gidx = 0;
        for (int k = 0; k < NR; k++) if (req_ready[k]) gidx = k;
        check("rr_order", 32'(gidx), 32'(gcount % NR));
        if (gcount > 0) check("rr_spacing", 32'(c - last_c), 32'd4);
        last_c = c;
        gcount++;
      end
      tick();
      #1;
    end
    check("rr_grants", 32'(gcount), 32'd5);
    drain();

    // Back-pressure: response held, no grants, resume after handshake.
    do_reset();
    set_slot(1, 8'h11, 5'b00010);
    set_slot(3, 8'h33, ZS);
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    tick(); tick(); tick();
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h22);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_valid", 32'(rsp_valid), 32'd1);
    check("bp_hs_ready", 32'(req_ready), 32'd0);
    tick();
    #1;
    check("bp_resume", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    #1;
    drain();

    // Reset while in WAIT abandons the transaction.
    set_slot(0, 8'h5A, 5'b00010);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check("rw_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("rw_issue_busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_rsp_data", 32'(rsp_data), 32'd0);
    check("rw_rsp_id", 32'(rsp_id), 32'd0);
    check("rw_rsp_err", 32'(rsp_err), 32'd0);
    check("rw_sh_ip", 32'(sh_ip), 32'd0);
    check("rw_sh_shift", 32'(sh_shift), 32'(ZS));
    check("rw_ready", 32'(req_ready), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen = 1;
      tick();
      #1;
    end
    check("rw_no_rsp", 32'(seen), 32'd0);

    // Randomised traffic against a transaction-level model.
    do_reset();
    ptr_m  = 0;
    m_busy = 1'b0;
    cd     = 0;
    e_id   = 0;
    e_err  = 1'b0;
    e_data = '0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) set_slot(i, 8'($urandom), rnd_shift());
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (!m_busy) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          j = (ptr_m + k) % NR;
          if (w < 0 && req_valid[j]) w = j;
        end
        exp_rdy = (w < 0) ? 4'b0000 : (4'b0001 << w);
        check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
        check("rnd_idle_valid", 32'(rsp_valid), 32'd0);
        if (w >= 0) begin
          m_busy = 1'b1;
          cd     = 3;
          e_id   = w;
          e_err  = ($countones(req_shift[w*SW +: SW]) > 1);
          e_data = model_shift(req_data[w*LEN +: LEN], model_sanitise(req_shift[w*SW +: SW]));
          ptr_m  = (w + 1) % NR;
        end
      end else begin
        check("rnd_busy_ready", 32'(req_ready), 32'd0);
        if (cd > 0) begin
          check("rnd_early_valid", 32'(rsp_valid), 32'd0);
        end else begin
          check("rnd_rsp_valid", 32'(rsp_valid), 32'd1);
          check("rnd_rsp_data", 32'(rsp_data), 32'(e_data));
          check("rnd_rsp_id", 32'(rsp_id), 32'(e_id));
          check("rnd_rsp_err", 32'(rsp_err), 32'(e_err));
          if (rsp_ready) m_busy = 1'b0;
        end
      end
      tick();
      if (m_busy && cd > 0) cd--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_shift_scheduler.md
# spike_shift_scheduler

Round-robin scheduler that shares one registered bi-directional spike shifter (thermometer/spike-volley datapath, one-hot shift magnitude, 1-cycle registered output) between `NUM_REQ` requesters. It accepts one spike volley plus shift magnitude per transaction, sequences it through the shifter, and returns the shifted volley tagged with the requester ID. It sits between the neuron/column front ends and the single shifter instance, which it drives directly.

## Interface

**Parameters**
- `LEN`, 8: spike volley width, bits `[0:LEN-1]`; index 0 is the latest time stamp, index LEN-1 is t=0.
- `MAX_SHIFT_MAG`, 2: shift range ±MAX_SHIFT_MAG; the shift field is `SW = 2*MAX_SHIFT_MAG+1` bits one-hot `[0:SW-1]`.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `IDW`, `$clog2(NUM_REQ)`: requester ID width.

**Ports**
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: request pending, per requester.
- `req_ready` out NUM_REQ: grant; at most one bit high per cycle.
- `req_data` in NUM_REQ×LEN: volley per requester.
- `req_shift` in NUM_REQ×SW: one-hot shift per requester.
- `sh_ip` out LEN: to shifter `Ip`.
- `sh_shift` out SW: to shifter `shift_mag`.
- `sh_op` in LEN: from shifter `Op`, valid 1 cycle after issue.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out LEN: shifted volley.
- `rsp_id` out IDW: requester that owns the response.
- `rsp_err` out 1: request had an illegal (multi-hot) shift.
- `busy` out 1: high in any state other than IDLE.

## Operation

**FSM states**
- **IDLE**
  - `req_ready` is asserted combinationally to the round-robin winner among the `req_valid` bits, starting the search at `rr_ptr`.
  - On `req_valid[w] & req_ready[w]`:
    - latch `req_data[w]`, the sanitised shift and `w`;
    - set `rr_ptr = (w+1) mod NUM_REQ`;
    - go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - Drive `sh_ip`/`sh_shift` from the latched registers. The shifter samples them at the end of this cycle.
  - Go to WAIT.
- **WAIT**
  - `sh_op` is valid. Capture it into `rsp_data`.
  - Go to RESP.
- **RESP**
  - Hold `rsp_valid=1` with stable `rsp_data`/`rsp_id`/`rsp_err`.
  - On `rsp_ready`, go to IDLE.
  - No new grant is issued while in RESP.

**Shift sanitising**
- An all-zero shift is legal and is passed as `ZERO_SHIFT`: only the centre bit `MAX_SHIFT_MAG` is set, meaning 0 shift.
- A single-hot shift is passed unchanged.
- A multi-hot shift is replaced with `ZERO_SHIFT`, and `rsp_err` is set for that transaction.

**Idle outputs**
- Outside ISSUE: `sh_ip=0`, `sh_shift=ZERO_SHIFT`.

## Timing

- **Latency:** handshake in cycle T (IDLE), `sh_ip` driven in T+1, captured in T+2, `rsp_valid` first high in T+3.
- **Throughput:**
  - Minimum period is 4 cycles per transaction when `rsp_ready` is held high.
  - With `rsp_ready` held high, `rsp_valid` is high for exactly 1 cycle.
  - After the response handshake in T+3, IDLE in T+4 can grant the next request.
- **Arbitration:**
  - Fair round-robin.
  - A requester that drops `req_valid` before it is granted loses nothing; the pointer does not advance.
- **Simultaneous events:**
  - All requesters valid: grants in order `rr_ptr`, `rr_ptr+1`, …
  - A `req_valid` edge in the same cycle as a grant has no effect on the grant already made.
- **Back-pressure:**
  - `rsp_ready` low holds RESP indefinitely.
  - `req_ready` stays all-zero during back-pressure.
- **Reset values:**
  - Registers: state=IDLE, `rr_ptr=0`.
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `rsp_err=0`, `busy=0`, `sh_ip=0`, `sh_shift=ZERO_SHIFT`.
  - Reset during ISSUE/WAIT/RESP abandons the in-flight transaction: no response is produced, and the shifter output arriving afterwards is ignored.
  - `req_ready` is 0 in the reset cycle.

## Structure

- **Package `spike_shift_pkg`:**
  - state enum `sched_state_t` (IDLE, ISSUE, WAIT, RESP);
  - function `shift_w(max_mag)`;
  - function `zero_shift(max_mag)`;
  - function `is_onehot_or_zero`.
- **Sub-module `rr_arbiter`:** parameter NUM_REQ. It takes `req`, `ptr` and an enable input, and returns a one-hot grant plus the binary winner ID. It is purely combinational. The pointer register stays in the scheduler.
- The shifter is not instantiated inside this block; the bench connects it externally.

## Test plan

The bench uses LEN=8, MAX_SHIFT_MAG=2 and NUM_REQ=4, with an external shifter that has no wrap-around.

1. **Single +1 shift.** req0, data `8'b0000_0010`, shift `5'b00010` at cycle T.
   - `rsp_valid` at T+3.
   - `rsp_data=8'b0000_0100`, `rsp_id=0`, `rsp_err=0`.
2. **Round-robin order.** All four requesters valid continuously, `rsp_ready=1`.
   - Grant order is 0,1,2,3,0.
   - Successive grants are spaced 4 cycles apart.
3. **Illegal shift.** req2, data `8'b0110_0011`, shift `5'b10010`.
   - `sh_shift=5'b00100` during ISSUE.
   - `rsp_data=8'b0110_0011`, `rsp_err=1`, `rsp_id=2`.
4. **Back-pressure.** `rsp_ready=0` for 10 cycles while req1 and req3 are valid.
   - `rsp_valid` and its data stay stable.
   - `req_ready=0` throughout.
   - Granting resumes in the cycle after the `rsp_ready` handshake.
5. **Reset in WAIT.** Assert `reset` while in WAIT.
   - The next cycle shows IDLE with all reset values.
   - No `rsp_valid` pulse appears for the abandoned request.
6. **Zero and -2 shifts.**
   - req3, shift `5'b00000`, data `8'b0000_1000` → `rsp_data=8'b0000_1000`.
   - req3, shift `5'b10000`, same data → `rsp_data=8'b0000_0010`.
